// File: rtl/sipo_deser.sv
// sipo_deser: serial-to-parallel deserializer with per-word bit order,
// valid/ready holding register and sticky overflow on dropped words.
module sipo_deser #(
    parameter int DW = 8,
    localparam int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          enb,
    input  logic          inp,
    input  logic          msb_first,
    output logic [DW-1:0] out,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [CW-1:0] bit_cnt,
    output logic          ovf
);
    logic [DW-1:0] sr, sr_nxt;
    logic          ord, ord_eff, done, free;

    // the first bit of a word follows the live order input, later bits the latch
    always_comb begin
        ord_eff = (bit_cnt == '0) ? msb_first : ord;
        sr_nxt  = ord_eff ? {sr[DW-2:0], inp} : {inp, sr[DW-1:1]};
        done    = enb && (bit_cnt == CW'(DW - 1));
        free    = !out_vld || out_rdy;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            ord     <= 1'b0;
            out     <= '0;
            out_vld <= 1'b0;
            ovf     <= 1'b0;
        end else if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
            out     <= '0;
            out_vld <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (enb) begin
                sr      <= sr_nxt;
                bit_cnt <= done ? '0 : bit_cnt + 1'b1;
                if (bit_cnt == '0)
                    ord <= msb_first;
            end
            // a completed word lands only if the holding register is free or being drained
            if (done && free) begin
                out     <= sr_nxt;
                out_vld <= 1'b1;
            end else if (done) begin
                ovf <= 1'b1;
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: randomized and directed scoreboard bench for sipo_deser.
module tb_sipo_deser;
    localparam int DW = 8;
    localparam int CW = $clog2(DW);

    logic          clk = 1'b0;
    logic          rst, clr, enb, inp, msb_first, out_rdy;
    logic [DW-1:0] out;
    logic          out_vld, ovf;
    logic [CW-1:0] bit_cnt;

    int            checks = 0;
    int            failures = 0;
    logic          bits[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ord, m_vld, m_ovf;

    always #5 clk = ~clk;

    sipo_deser #(.DW(DW)) dut (
        .clk(clk), .rst(rst), .clr(clr), .enb(enb), .inp(inp),
        .msb_first(msb_first), .out(out), .out_vld(out_vld),
        .out_rdy(out_rdy), .bit_cnt(bit_cnt), .ovf(ovf)
    );

    function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    function automatic void model_reset();
        bits.delete();
        exp_q.delete();
        m_ord = 1'b0;
        m_vld = 1'b0;
        m_ovf = 1'b0;
    endfunction

    // one clock: drive inputs, let the edge happen, then advance the reference model
    task automatic cyc(input logic e, input logic i, input logic m, input logic r, input logic c);
        logic [DW-1:0] w;
        logic          taken;
        enb = e; inp = i; msb_first = m; out_rdy = r; clr = c;
        @(posedge clk);
        #1;
        taken = m_vld && r;
        if (c) begin
            bits.delete();
            exp_q.delete();
            m_vld = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (e) begin
                if (bits.size() == 0) m_ord = m;
                bits.push_back(i);
            end
            if (bits.size() == DW) begin
                w = '0;
                for (int k = 0; k < DW; k++) w[m_ord ? DW-1-k : k] = bits[k];
                bits.delete();
                if (!m_vld || r) begin
                    exp_q.push_back(w);
                    m_vld = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (taken) begin
                m_vld = 1'b0;
            end
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input logic m, input logic r, input int tog);
        for (int k = 0; k < DW; k++)
            cyc(1'b1, w[m ? DW-1-k : k], (k >= tog) ? ~m : m, r, 1'b0);
    endtask

    task automatic idle(input logic r);
        cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("out_vld", out_vld, m_vld);
            chk("ovf", ovf, m_ovf);
            chk("bit_cnt", bit_cnt, bits.size());
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL word: got %0h while no word was expected", out);
                end else begin
                    chk("word", out, exp_q[0]);
                    if (out_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b0; clr = 1'b0; enb = 1'b0; inp = 1'b0; msb_first = 1'b0; out_rdy = 1'b0;
        model_reset();
        #12;
        chk("rst_out", out, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_cnt", bit_cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b1;

        send_word(8'h0D, 1'b0, 1'b0, DW);
        chk("lsb_word", out, 8'h0D);
        chk("lsb_cnt", bit_cnt, 0);
        idle(1'b1);
        send_word(8'hB0, 1'b1, 1'b0, DW);
        chk("msb_word", out, 8'hB0);
        idle(1'b1);
        send_word(8'h5A, 1'b1, 1'b0, 3);
        chk("msb_toggle_word", out, 8'h5A);
        idle(1'b1);

        send_word(8'hA5, 1'b0, 1'b1, DW);
        chk("b2b_first", out, 8'hA5);
        send_word(8'h3C, 1'b0, 1'b1, DW);
        chk("b2b_second", out, 8'h3C);
        chk("b2b_ovf", ovf, 0);
        idle(1'b1);

        send_word(8'h11, 1'b0, 1'b0, DW);
        send_word(8'h22, 1'b0, 1'b0, DW);
        chk("drop_keep", out, 8'h11);
        chk("drop_ovf", ovf, 1);
        idle(1'b1);
        chk("drain_vld", out_vld, 0);
        chk("drain_ovf", ovf, 1);

        send_word(8'h77, 1'b0, 1'b0, DW);
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("arst_out", out, 0);
        chk("arst_vld", out_vld, 0);
        chk("arst_cnt", bit_cnt, 0);
        chk("arst_ovf", ovf, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        send_word(8'hC3, 1'b0, 1'b0, DW);
        chk("post_rst_word", out, 8'hC3);
        idle(1'b1);

        send_word(8'h01, 1'b0, 1'b0, DW);
        send_word(8'h02, 1'b0, 1'b0, DW);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("clr_cnt", bit_cnt, 0);
        chk("clr_vld", out_vld, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_out", out, 0);
        send_word(8'h9E, 1'b0, 1'b0, DW);
        chk("post_clr_word", out, 8'h9E);
        idle(1'b1);

        repeat (800)
            cyc($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
